// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: constants and state encoding shared by the UART receive path.
// The bit period lives here so the TX and RX paths agree on one value.
package uart_rx_pkg;

    // Clocks per bit: 54 gives 921600 baud at 50 MHz, 434 gives 115200.
    localparam int UART_CLKS_PER_BIT = 54;

    // Data bits per 8N1 frame.
    localparam int UART_DATA_BITS = 8;

    // Receiver states.
    typedef enum logic [1:0] {
        UART_RX_IDLE  = 2'd0,
        UART_RX_START = 2'd1,
        UART_RX_DATA  = 2'd2,
        UART_RX_STOP  = 2'd3
    } uart_rx_state_t;

    // Half a bit period, rounded down; the start bit is checked at this offset
    // so every later sample lands in the middle of its bit.
    function automatic int half_bit(input int clks_per_bit);
        return clks_per_bit / 2;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// sync_2ff: two-flop synchroniser for asynchronous inputs, with a
// configurable width and reset value so it can be reused for buttons
// and switches as well as serial lines.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // First flop may go metastable; the second gives it a full cycle to settle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver. Synchronises rxd, detects the start edge,
// samples eight data bits LSB-first at mid-bit, checks the stop bit and
// hands good bytes to a single-entry holding register with valid/ack.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int HALF  = half_bit(CLKS_PER_BIT);

    // Terminal counts: the start check happens H cycles after the edge,
    // every later sample a full bit period after the previous one.
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [3:0]       LAST_BIT  = 4'(UART_DATA_BITS - 1);

    logic           rxd_s;
    logic           rxd_p;
    uart_rx_state_t state;
    logic [CNT_W-1:0] cnt;
    logic [3:0]     bit_cnt;
    logic [7:0]     shreg;

    sync_2ff #(
        .WIDTH     (1),
        .RESET_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    // Previous synchronised level, so a start is a high-to-low edge and a
    // line stuck low cannot retrigger the receiver.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rxd_p <= 1'b1;
        end else begin
            rxd_p <= rxd_s;
        end
    end

    // Receive FSM with bit timing, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= UART_RX_IDLE;
            cnt        <= '0;
            bit_cnt    <= '0;
            shreg      <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            // The consumer's ack frees the holding register; a good stop bit
            // on the same edge re-sets valid further down.
            if (data_valid && data_ack) begin
                data_valid <= 1'b0;
            end

            case (state)
                UART_RX_IDLE: begin
                    if (rxd_p && !rxd_s) begin
                        state <= UART_RX_START;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end

                UART_RX_START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!rxd_s) begin
                            state   <= UART_RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            // Line went back high: a glitch, not a start bit.
                            state <= UART_RX_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                UART_RX_DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxd_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= UART_RX_STOP;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                UART_RX_STOP: begin
                    if (cnt == BIT_LAST) begin
                        // Leave mid-stop-bit so the next start edge is never missed.
                        cnt   <= '0;
                        state <= UART_RX_IDLE;
                        busy  <= 1'b0;
                        if (rxd_s) begin
                            data       <= shreg;
                            data_valid <= 1'b1;
                            if (data_valid && !data_ack) begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state <= UART_RX_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed bench for uart_rx with a table of whole frames plus
// hand-written sequences for glitches, breaks, overrun and mid-frame reset.
module tb_uart_rx;

    localparam int N = 54;

    // Edges from the start-bit drive to the edge that registers the result:
    // 2 synchroniser flops, 1 detect edge, then H + 9N.
    localparam int DONE_EDGES  = 3 + (N / 2) + 9 * N;
    localparam int FALSE_EDGES = 3 + (N / 2);

    logic       clk = 1'b0;
    logic       rst;
    logic       rxd;
    logic       data_ack;
    logic [7:0] data;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int n_compared   = 0;
    int n_mismatched = 0;

    int edge_cnt   = 0;
    int start_edge = 0;

    int valid_rises     = 0;
    int busy_rises      = 0;
    int fe_cnt          = 0;
    int fe_long         = 0;
    int ov_cnt          = 0;
    int ov_long         = 0;
    int last_valid_edge = 0;
    int last_fe_edge    = 0;
    int last_ov_edge    = 0;
    int last_busy_fall  = 0;

    logic prev_valid = 1'b0;
    logic prev_fe    = 1'b0;
    logic prev_ov    = 1'b0;
    logic prev_busy  = 1'b0;

    typedef struct {
        logic [7:0] tx_byte;
        logic       stop_bit;
        int         period;
        logic [7:0] exp_data;
        logic       exp_valid;
        int         exp_fe;
    } vec_t;

    vec_t vecs[7];

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .rxd        (rxd),
        .data       (data),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt++;

    // Event monitor: records when outputs change, sampled away from the edge.
    always @(negedge clk) begin
        if (data_valid && !prev_valid) begin
            valid_rises++;
            last_valid_edge = edge_cnt;
        end
        if (frame_err) begin
            fe_cnt++;
            last_fe_edge = edge_cnt;
            if (prev_fe) fe_long++;
        end
        if (overrun) begin
            ov_cnt++;
            last_ov_edge = edge_cnt;
            if (prev_ov) ov_long++;
        end
        if (busy && !prev_busy) busy_rises++;
        if (!busy && prev_busy) last_busy_fall = edge_cnt;
        prev_valid = data_valid;
        prev_fe    = frame_err;
        prev_ov    = overrun;
        prev_busy  = busy;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Sends one frame; called and returns on a falling clock edge.
    task automatic applyStimulus(input logic [7:0] b, input logic stop_bit,
                                 input int period);
        rxd = 1'b0;
        start_edge = edge_cnt;
        repeat (period) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (period) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (period) @(negedge clk);
    endtask

    task automatic pulseAck();
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
    endtask

    initial begin
        int fe0, vr0, ov0, br0, s1;

        vecs[0] = '{8'hA5, 1'b1, 54, 8'hA5, 1'b1, 0};
        vecs[1] = '{8'h3C, 1'b1, 54, 8'h3C, 1'b1, 0};
        vecs[2] = '{8'h00, 1'b1, 54, 8'h00, 1'b1, 0};
        vecs[3] = '{8'hC3, 1'b0, 54, 8'h00, 1'b0, 1};
        vecs[4] = '{8'hFF, 1'b1, 54, 8'hFF, 1'b1, 0};
        vecs[5] = '{8'h55, 1'b1, 52, 8'h55, 1'b1, 0};
        vecs[6] = '{8'h55, 1'b1, 56, 8'h55, 1'b1, 0};

        rst      = 1'b0;
        rxd      = 1'b1;
        data_ack = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset data", 32'(data), 32'h00);
        checkOutput("reset data_valid", 32'(data_valid), 32'h0);
        checkOutput("reset frame_err", 32'(frame_err), 32'h0);
        checkOutput("reset overrun", 32'(overrun), 32'h0);
        checkOutput("reset busy", 32'(busy), 32'h0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Table of whole frames, each preceded by an ack to empty the register.
        for (int v = 0; v < 7; v++) begin
            pulseAck();
            fe0 = fe_cnt;
            vr0 = valid_rises;
            applyStimulus(vecs[v].tx_byte, vecs[v].stop_bit, vecs[v].period);
            rxd = 1'b1;
            repeat (3 * vecs[v].period) @(negedge clk);
            checkOutput($sformatf("vec%0d data", v), 32'(data), 32'(vecs[v].exp_data));
            checkOutput($sformatf("vec%0d data_valid", v), 32'(data_valid),
                        32'(vecs[v].exp_valid));
            checkOutput($sformatf("vec%0d frame_err count", v), 32'(fe_cnt - fe0),
                        32'(vecs[v].exp_fe));
            checkOutput($sformatf("vec%0d valid rises", v), 32'(valid_rises - vr0),
                        32'(vecs[v].exp_valid));
            if (vecs[v].period == N && vecs[v].exp_valid)
                checkOutput($sformatf("vec%0d valid latency", v),
                            32'(last_valid_edge - start_edge), 32'(DONE_EDGES));
            if (vecs[v].exp_fe != 0)
                checkOutput($sformatf("vec%0d frame_err latency", v),
                            32'(last_fe_edge - start_edge), 32'(DONE_EDGES));
        end
        checkOutput("frame_err pulse width", 32'(fe_long), 32'h0);

        // Glitch of 10 cycles: false start, then a normal frame.
        pulseAck();
        vr0 = valid_rises;
        br0 = busy_rises;
        rxd = 1'b0;
        start_edge = edge_cnt;
        repeat (10) @(negedge clk);
        rxd = 1'b1;
        repeat (2 * N) @(negedge clk);
        checkOutput("glitch busy rose", 32'(busy_rises - br0), 32'h1);
        checkOutput("glitch busy fall time", 32'(last_busy_fall - start_edge),
                    32'(FALSE_EDGES));
        checkOutput("glitch no valid", 32'(valid_rises - vr0), 32'h0);
        applyStimulus(8'h3C, 1'b1, N);
        repeat (2 * N) @(negedge clk);
        checkOutput("after glitch data", 32'(data), 32'h3C);
        checkOutput("after glitch valid", 32'(data_valid), 32'h1);

        // Framing error with an unread byte held: data and valid must not move.
        fe0 = fe_cnt;
        vr0 = valid_rises;
        applyStimulus(8'h81, 1'b0, N);
        checkOutput("ferr count", 32'(fe_cnt - fe0), 32'h1);
        checkOutput("ferr latency", 32'(last_fe_edge - start_edge), 32'(DONE_EDGES));
        checkOutput("ferr data kept", 32'(data), 32'h3C);
        checkOutput("ferr valid kept", 32'(data_valid), 32'h1);

        // Break: line stays low, nothing may happen.
        br0 = busy_rises;
        repeat (2000) @(negedge clk);
        checkOutput("break frame_err", 32'(fe_cnt - fe0), 32'h1);
        checkOutput("break busy", 32'(busy_rises - br0), 32'h0);
        checkOutput("break valid rises", 32'(valid_rises - vr0), 32'h0);
        rxd = 1'b1;
        repeat (3 * N) @(negedge clk);

        // Ack one cycle after a byte is held: valid drops on the next edge.
        checkOutput("pre-ack valid", 32'(data_valid), 32'h1);
        data_ack = 1'b1;
        @(negedge clk);
        checkOutput("post-ack valid", 32'(data_valid), 32'h0);
        data_ack = 1'b0;

        applyStimulus(8'h42, 1'b1, N);
        repeat (2 * N) @(negedge clk);
        checkOutput("after break data", 32'(data), 32'h42);
        checkOutput("after break valid", 32'(data_valid), 32'h1);

        // Overrun: two frames back to back with no ack.
        pulseAck();
        ov0 = ov_cnt;
        applyStimulus(8'h01, 1'b1, N);
        s1 = start_edge;
        applyStimulus(8'hFF, 1'b1, N);
        repeat (2 * N) @(negedge clk);
        checkOutput("overrun first frame start", 32'(start_edge - s1), 32'(10 * N));
        checkOutput("overrun count", 32'(ov_cnt - ov0), 32'h1);
        checkOutput("overrun latency", 32'(last_ov_edge - start_edge), 32'(DONE_EDGES));
        checkOutput("overrun pulse width", 32'(ov_long), 32'h0);
        checkOutput("overrun data", 32'(data), 32'hFF);
        checkOutput("overrun valid", 32'(data_valid), 32'h1);

        // Ack on the completion edge: new byte loads, no overrun.
        ov0 = ov_cnt;
        fork
            applyStimulus(8'h96, 1'b1, N);
            begin
                repeat (DONE_EDGES - 1) @(negedge clk);
                data_ack = 1'b1;
                @(negedge clk);
                data_ack = 1'b0;
            end
        join
        repeat (2 * N) @(negedge clk);
        checkOutput("ack-race overrun", 32'(ov_cnt - ov0), 32'h0);
        checkOutput("ack-race data", 32'(data), 32'h96);
        checkOutput("ack-race valid", 32'(data_valid), 32'h1);

        // Reset during bit 4 of a frame whose remaining bits are all high.
        vr0 = valid_rises;
        fork
            applyStimulus(8'hF0, 1'b1, N);
            begin
                repeat (5 * N + N / 2) @(negedge clk);
                checkOutput("pre-reset busy", 32'(busy), 32'h1);
                rst = 1'b0;
                @(negedge clk);
                checkOutput("mid reset data", 32'(data), 32'h00);
                checkOutput("mid reset valid", 32'(data_valid), 32'h0);
                checkOutput("mid reset frame_err", 32'(frame_err), 32'h0);
                checkOutput("mid reset overrun", 32'(overrun), 32'h0);
                checkOutput("mid reset busy", 32'(busy), 32'h0);
                rst = 1'b1;
            end
        join
        repeat (3 * N) @(negedge clk);
        checkOutput("post reset no valid", 32'(valid_rises - vr0), 32'h0);
        applyStimulus(8'h5A, 1'b1, N);
        repeat (2 * N) @(negedge clk);
        checkOutput("post reset data", 32'(data), 32'h5A);
        checkOutput("post reset valid", 32'(data_valid), 32'h1);
        checkOutput("post reset latency", 32'(last_valid_edge - start_edge),
                    32'(DONE_EDGES));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
